// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU (add/sub/shifts/logic ops) with carry, zero and overflow flags.
// Latency: a beat accepted at edge N is presented on d/out_valid after edge N+1.
// Backpressure: valid/ready; in_ready drops only when both stages are full and out_ready is low.

module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             Cout,
  output logic             Z,
  output logic             V,
  output logic [CNTW-1:0]  ovf_cnt,
  input  logic             ovf_clr
);

  // Shift amount width; WIDTH is a power of two so this selects exactly the low bits of b.
  localparam int SHW = $clog2(WIDTH);

  // Original encodings (add, sll, and) are kept at their legacy codes.
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  localparam logic [WIDTH:0] ONE_W1 = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  // Operand beat held in stage 1.
  typedef struct packed {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } opnd_t;

  // Result beat held in stage 2; flags travel with the data they describe.
  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             c;
    logic             z;
    logic             v;
  } res_t;

  logic           s1_v;
  opnd_t          s1_q;
  logic           s2_v;
  res_t           s2_q;
  res_t           res_c;

  logic           adv1;
  logic           adv2;
  logic           xfer;

  logic [WIDTH:0] sum_c;
  logic [WIDTH:0] dif_c;
  logic [SHW-1:0] sh;
  logic           a_msb;
  logic           b_msb;

  // Stage 2 can take a new beat when it is empty or its beat leaves this cycle;
  // stage 1 can take a beat when it is empty or its beat moves into stage 2.
  assign adv2     = !s2_v || out_ready;
  assign adv1     = !s1_v || adv2;
  assign in_ready = adv1;
  assign xfer     = s2_v && out_ready;

  // Result computation from the stage-1 operands; flags default to 0 so they are never X.
  always_comb begin
    sh    = s1_q.b[SHW-1:0];
    a_msb = s1_q.a[WIDTH-1];
    b_msb = s1_q.b[WIDTH-1];
    // Subtraction as a + ~b + 1 so the carry out means "no borrow".
    sum_c = {1'b0, s1_q.a} + {1'b0, s1_q.b};
    dif_c = {1'b0, s1_q.a} + {1'b0, ~s1_q.b} + ONE_W1;
    res_c = '0;
    case (s1_q.op)
      OP_ADD: begin
        res_c.d = sum_c[WIDTH-1:0];
        res_c.c = sum_c[WIDTH];
        res_c.v = (a_msb == b_msb) && (sum_c[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        res_c.d = dif_c[WIDTH-1:0];
        res_c.c = dif_c[WIDTH];
        res_c.v = (a_msb != b_msb) && (dif_c[WIDTH-1] != a_msb);
      end
      OP_SLL: res_c.d = s1_q.a << sh;
      OP_SRL: res_c.d = s1_q.a >> sh;
      OP_SRA: res_c.d = $unsigned($signed(s1_q.a) >>> sh);
      OP_OR:  res_c.d = s1_q.a | s1_q.b;
      OP_XOR: res_c.d = s1_q.a ^ s1_q.b;
      OP_AND: res_c.d = s1_q.a & s1_q.b;
    endcase
    res_c.z = (res_c.d == '0);
  end

  // Stage 1: capture an operand beat whenever the stage is free to advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (adv1) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_q <= '{op: ALUop, a: a, b: b};
      end
    end
  end

  // Stage 2: register the result; data only loads with a valid beat so a stall holds it stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2_q <= '0;
    end else if (adv2) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_q <= res_c;
      end
    end
  end

  // Overflow event counter: counts delivered results with V set, saturates, clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (xfer && s2_q.v && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + CNTW'(1);
    end
  end

  assign out_valid = s2_v;
  assign d         = s2_q.d;
  assign Cout      = s2_q.c;
  assign Z         = s2_q.z;
  assign V         = s2_q.v;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized and directed checks of alu_pipe against a behavioural model.
// Latency: results are expected two observation cycles after acceptance when unstalled.
// Backpressure: out_ready is toggled to exercise stalls, full-pipe and reset discard.

module tb_alu_pipe;
  localparam int W  = 32;
  localparam int CW = 2;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    ALUop;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  d;
  logic          Cout;
  logic          Z;
  logic          V;
  logic [CW-1:0] ovf_cnt;
  logic          ovf_clr;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .CNTW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .Cout(Cout), .Z(Z), .V(V), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [31:0] d;
    bit          c;
    bit          z;
    bit          v;
    int          acc;
    bit          has_k;
    logic [31:0] kd;
    bit          kc;
    bit          kz;
    bit          kv;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          mcnt    = 0;
  bit          lat_chk = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_d;
  bit          last_acc = 0;
  bit          k_pend = 0;
  logic [31:0] k_d;
  bit          k_c;
  bit          k_z;
  bit          k_v;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // Reference: results from true integer arithmetic rather than bit-level carry logic.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sv;
    longint      uv;
    int          sh;
    e.d = 0; e.c = 0; e.z = 0; e.v = 0; e.acc = 0; e.has_k = 0; e.kd = 0;
    e.kc = 0; e.kz = 0; e.kv = 0;
    sh = int'(y % 32);
    case (op)
      3'd0: begin
        uv  = longint'({32'd0, x}) + longint'({32'd0, y});
        sv  = longint'($signed(x)) + longint'($signed(y));
        e.d = uv[31:0];
        e.c = (uv >= 64'h1_0000_0000);
        e.v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      3'd2: begin
        uv  = longint'({32'd0, x}) - longint'({32'd0, y});
        sv  = longint'($signed(x)) - longint'($signed(y));
        e.d = uv[31:0];
        e.c = (x >= y);
        e.v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      3'd1: e.d = x << sh;
      3'd3: e.d = x >> sh;
      3'd4: e.d = $unsigned($signed(x) >>> sh);
      3'd5: e.d = x | y;
      3'd6: e.d = x ^ y;
      default: e.d = x & y;
    endcase
    e.z = (e.d == 0);
    return e;
  endfunction

  // One clock: inputs are already driven; observe #1 later, account for the edge, then check.
  task automatic tick();
    exp_t e;
    bit   xv;
    bit   rs;
    bit   ov_exp;
    #1;
    rs = rst_n;
    xv = 0;
    last_acc = 0;
    if (rs) begin
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      ov_exp = 0;
      if (q.size() > 0) ov_exp = ((cyc - q[0].acc) >= 2);
      chk("out_valid", out_valid, ov_exp);
      if (prev_stall) chk("hold_d", d, prev_d);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = q.pop_front();
          chk("d", d, e.d);
          chk("cout", Cout, e.c);
          chk("z", Z, e.z);
          chk("v", V, e.v);
          if (e.has_k) begin
            chk("k_d", d, e.kd);
            chk("k_cout", Cout, e.kc);
            chk("k_z", Z, e.kz);
            chk("k_v", V, e.kv);
          end
          if (lat_chk) chk("latency", cyc - e.acc, 2);
          xv = e.v;
        end
      end
      if (in_valid && in_ready) begin
        e = model(ALUop, a, b);
        e.acc = cyc;
        if (k_pend) begin
          e.has_k = 1; e.kd = k_d; e.kc = k_c; e.kz = k_z; e.kv = k_v;
          k_pend = 0;
        end
        q.push_back(e);
        last_acc = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = d;
      if (ovf_clr) mcnt = 0;
      else if (xv && mcnt < CMAX) mcnt++;
    end
    @(negedge clk);
    cyc++;
    if (!rs) begin
      q.delete();
      mcnt = 0;
      prev_stall = 0;
    end
    chk("ovf_cnt", ovf_cnt, mcnt);
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    in_valid = 1; ALUop = op; a = x; b = y;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) chk("accept_timeout", last_acc, 1);
    in_valid = 0;
  endtask

  task automatic send_k(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] kd, input bit kc, input bit kz, input bit kv);
    k_pend = 1; k_d = kd; k_c = kc; k_z = kz; k_v = kv;
    send(op, x, y);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 0;
    out_ready = 1;
    while ((q.size() != 0 || out_valid) && n < 20) begin
      tick();
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 1; ovf_clr = 0;
    ALUop = 0; a = 0; b = 0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d", d, 0);
    chk("rst_cout", Cout, 0);
    chk("rst_z", Z, 0);
    chk("rst_v", V, 0);
    chk("rst_ovf", ovf_cnt, 0);
    rst_n = 1;
    tick();
    chk("in_ready_after_rst", in_ready, 1);

    // Adds with overflow, latency checked.
    lat_chk = 1;
    send_k(3'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0, 1);
    send_k(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1, 1, 1);
    drain();
    chk("ovf_after_adds", ovf_cnt, 2);

    // Shifts and subtracts.
    send_k(3'd1, 32'h8000_000F, 32'h1C,  32'hF000_0000, 0, 0, 0);
    send_k(3'd1, 32'h8000_000F, 32'h100, 32'h8000_000F, 0, 0, 0);
    send_k(3'd3, 32'h8000_000F, 32'h4,   32'h0800_0000, 0, 0, 0);
    send_k(3'd4, 32'h8000_000F, 32'h4,   32'hF800_0000, 0, 0, 0);
    send_k(3'd2, 32'h5, 32'h7, 32'hFFFF_FFFE, 0, 0, 0);
    send_k(3'd2, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1, 0, 1);
    send_k(3'd2, 32'h3, 32'h3, 32'h0, 1, 1, 0);
    drain();
    lat_chk = 0;

    // Backpressure: two accepts fill the pipe, third beat waits three cycles.
    out_ready = 0;
    send(3'd0, 32'd1, 32'd2);
    send(3'd0, 32'd3, 32'd4);
    in_valid = 1; ALUop = 3'd0; a = 32'd5; b = 32'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_d_hold", d, 32'd3);
    end
    out_ready = 1;
    send(3'd0, 32'd5, 32'd6);
    send(3'd0, 32'd7, 32'd8);
    drain();

    // Counter saturation, then clear coinciding with an overflow transfer.
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    for (int i = 0; i < 5; i++) send(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    drain();
    chk("ovf_sat", ovf_cnt, 3);
    send(3'd0, 32'h7FFF_FFFF, 32'h1);
    for (int i = 0; i < 10 && !out_valid; i++) tick();
    chk("clr_wait_valid", out_valid, 1);
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    chk("ovf_clr_prio", ovf_cnt, 0);

    // Reset with two beats in flight discards them.
    out_ready = 0;
    send(3'd0, 32'h7FFF_FFFF, 32'h1);
    send(3'd6, 32'h5, 32'h3);
    chk("pre_rst_full", in_ready, 0);
    rst_n = 0;
    tick();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_d", d, 0);
    chk("mid_rst_cout", Cout, 0);
    chk("mid_rst_z", Z, 0);
    chk("mid_rst_v", V, 0);
    chk("mid_rst_ovf", ovf_cnt, 0);
    rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("no_stale", out_valid, 0);

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      ALUop     = 3'($urandom_range(0, 7));
      a         = pick();
      b         = pick();
      out_ready = ($urandom_range(0, 3) != 0);
      ovf_clr   = ($urandom_range(0, 40) == 0);
      tick();
    end
    ovf_clr = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the team's 32-bit combinational ALU. It keeps the original add, shift-left and AND encodings and adds sub, logical/arithmetic right shift, OR and XOR. Operands enter through a valid/ready handshake and pass through a two-stage registered pipeline with full backpressure. A saturating overflow counter is included for datapath diagnostics. The block sits between the operand-issue logic and the writeback stage.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a power of two and at least 8.
- CNTW, 8, width of the overflow event counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- ALUop  in  3  operation code; encodings under Operation.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result this cycle.
- d  out  WIDTH  result.
- Cout, Z, V  out  1 each  carry, zero and signed-overflow flags, aligned with d.
- ovf_cnt  out  CNTW  number of accepted results with V=1, saturating at all-ones.
- ovf_clr  in  1  synchronous clear of ovf_cnt.

## Operation
- ALUop encodings:
  - 000 add: d=a+b.
  - 001 sll: d=a<<sh.
  - 010 sub: d=a-b.
  - 011 srl: d=a>>sh, zero fill.
  - 100 sra: d=a>>>sh, sign fill.
  - 101 or.
  - 110 xor.
  - 111 and.
- Shift amount sh=b[log2(WIDTH)-1:0]. Upper bits of b are ignored, so for WIDTH=32, b=0x100 shifts by 0.
- add: computed as WIDTH+1-bit sum; Cout=carry out of the MSB.
- sub: computed as a+~b+1; Cout=carry out of the MSB (1 means no borrow).
- V, add: operands have the same sign and the result sign differs.
- V, sub: operand signs differ and the result sign differs from a.
- For all non-add/sub ops, Cout=0 and V=0. These flags are never X.
- Z=1 iff d==0, for every op.
- Stage S1 registers ALUop, a, b and a valid bit s1_v.
- Stage S2 registers d, Cout, Z, V (computed combinationally from S1) and a valid bit s2_v. out_valid=s2_v.
- Handshake:
  - adv2 = !s2_v || out_ready.
  - adv1 = !s1_v || adv2.
  - in_ready = adv1, a combinational function of out_ready and state only.
  - An input beat is accepted when in_valid && in_ready.
  - S2 loads from S1 when adv2. S2's valid bit takes s1_v.
- While out_valid && !out_ready, d and the flags hold stable and no beat is lost or duplicated.
- ovf_cnt:
  - Increments by 1 on each output transfer (out_valid && out_ready) with V=1.
  - Saturates at 2^CNTW-1.
  - ovf_clr has priority: if it coincides with an incrementing transfer, the counter ends at 0.

## Timing
- Reset (rst_n=0 at a clock edge):
  - s1_v=0, s2_v=0, out_valid=0.
  - d=0, Cout=0, Z=0, V=0, ovf_cnt=0.
  - in_ready reads 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight beats. Nothing is emitted after reset until a new beat is accepted.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1, provided S2 was free or draining.
- Throughput: 1 beat/cycle with out_ready held at 1.
- Full condition: s1_v=1, s2_v=1 and out_ready=0 gives in_ready=0. At most 2 beats are in flight.
- Simultaneous accept and drain on a full pipe is allowed. If out_ready=1, in_ready=1 in the same cycle and both stages shift.
- Changing in_valid, a, b or ALUop while in_ready=0 has no effect.

## Test plan
- WIDTH=32, out_ready=1: add 0x7FFFFFFF+1, then add 0x80000000+0x80000000. Expect d=0x80000000 with V=1, C=0, Z=0; then d=0 with C=1, Z=1, V=1. Each result appears 2 cycles after accept, and ovf_cnt=2 afterwards.
- Shifts with a=0x8000000F:
  - sll b=0x1C gives 0xF0000000.
  - sll b=0x100 gives 0x8000000F.
  - srl b=4 gives 0x08000000.
  - sra b=4 gives 0xF8000000.
  - In all cases C=0 and V=0.
- sub: 5-7 gives 0xFFFFFFFE, C=0, V=0. 0x80000000-1 gives 0x7FFFFFFF, C=1, V=1. 3-3 gives Z=1, C=1.
- Backpressure: stream 4 adds with out_ready=0 for 3 cycles. in_ready drops after 2 accepts and d holds. On release, all 4 results arrive in order with none lost or duplicated.
- Saturation and clear with CNTW=2: 5 overflowing adds leave ovf_cnt=3. Assert ovf_clr in the same cycle as an overflow transfer and expect ovf_cnt=0.
- Mid-stream rst_n=0 with 2 beats in flight: out_valid=0 and all outputs=0 on the next cycle, and no stale result is emitted afterwards.
